// File: rtl/cpu_pkg.sv
// Shared definitions for the five-stage MIPS core: exception codes, control-vector
// layout, T_new width and the pipeline-register update-mode selector.
package cpu_pkg;

  localparam logic [31:0] EXC_VEC_DEFAULT = 32'h0000_4180;

  localparam int unsigned EXC_W  = 5;
  localparam int unsigned TNEW_W = 3;

  // Int cannot use code 0 because 0 means "no exception" in the pipeline
  localparam logic [EXC_W-1:0] EXC_NONE    = EXC_W'(0);
  localparam logic [EXC_W-1:0] EXC_INT     = EXC_W'(16);
  localparam logic [EXC_W-1:0] EXC_ADEL    = EXC_W'(4);
  localparam logic [EXC_W-1:0] EXC_ADES    = EXC_W'(5);
  localparam logic [EXC_W-1:0] EXC_SYSCALL = EXC_W'(8);
  localparam logic [EXC_W-1:0] EXC_RI      = EXC_W'(10);
  localparam logic [EXC_W-1:0] EXC_OV      = EXC_W'(12);

  localparam int unsigned CTRL_MEMTOREG_BIT = 0;
  localparam int unsigned CTRL_REGWRITE_BIT = 1;
  localparam int unsigned CTRL_MEMWRITE_BIT = 2;
  localparam int unsigned CTRL_MEMOP_LSB    = 3;
  localparam int unsigned CTRL_MEMOP_W      = 2;
  localparam int unsigned CTRL_C0WRITE_BIT  = 5;
  localparam int unsigned CTRL_EXLCLR_BIT   = 6;
  localparam int unsigned CTRL_SPARE_BIT    = 7;

  typedef enum logic [2:0] {
    STG_HOLD     = 3'd0,
    STG_REDIRECT = 3'd1,
    STG_BUBBLE   = 3'd2,
    STG_SQUASH   = 3'd3,
    STG_CAPTURE  = 3'd4
  } stg_op_e;

  // Update priority: req > flush > stall > squash > capture
  function automatic stg_op_e stg_op_sel(input logic req, input logic flush,
                                         input logic stall, input logic squash);
    stg_op_e op;
    if (req)         op = STG_REDIRECT;
    else if (flush)  op = STG_BUBBLE;
    else if (stall)  op = STG_HOLD;
    else if (squash) op = STG_SQUASH;
    else             op = STG_CAPTURE;
    return op;
  endfunction

endpackage

// File: rtl/tnew_sat_dec.sv
// Saturating decrement-by-one; shared by the pipeline registers and the hazard unit.
module tnew_sat_dec #(
  parameter int unsigned W = 3
) (
  input  logic [W-1:0] value,
  output logic [W-1:0] dec_c
);

  always_comb begin
    dec_c = value;
    if (value != '0) dec_c = value - W'(1);
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with redirect/bubble/hold/squash/capture modes.
// Optional trace register for instr enabled by PIPE_INSTR_TRACE_EN.
module pipe_stage_reg #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned N_WORDS = 2,
  parameter int unsigned CTRL_W  = 8,
  parameter int unsigned REG_W   = 5,
  parameter int unsigned N_REGS  = 4,
  parameter int unsigned TNEW_W  = cpu_pkg::TNEW_W,
  parameter int unsigned EXC_W   = cpu_pkg::EXC_W,
  parameter logic [31:0] EXC_VEC = cpu_pkg::EXC_VEC_DEFAULT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req,
  input  logic                      flush,
  input  logic                      stall,
  input  logic                      valid_in,
  input  logic [CTRL_W-1:0]         ctrl_in,
  input  logic [N_WORDS*DATA_W-1:0] data_in,
  input  logic [N_REGS*REG_W-1:0]   regs_in,
  input  logic [31:0]               pc_in,
  input  logic [TNEW_W-1:0]         tnew_in,
  input  logic [EXC_W-1:0]          exc_in,
  input  logic                      bd_in,
  input  logic [31:0]               instr_in,
  output logic                      valid_out,
  output logic [CTRL_W-1:0]         ctrl_out,
  output logic [N_WORDS*DATA_W-1:0] data_out,
  output logic [N_REGS*REG_W-1:0]   regs_out,
  output logic [31:0]               pc_out,
  output logic [TNEW_W-1:0]         tnew_out,
  output logic [EXC_W-1:0]          exc_out,
  output logic                      bd_out,
  output logic [31:0]               instr_out
);

  import cpu_pkg::*;

  localparam int unsigned DATA_BITS = N_WORDS * DATA_W;
  localparam int unsigned REG_BITS  = N_REGS * REG_W;

  stg_op_e op_c;
  logic    squash_c;

  logic                  valid_q, valid_d;
  logic [CTRL_W-1:0]     ctrl_q,  ctrl_d;
  logic [DATA_BITS-1:0]  data_q,  data_d;
  logic [REG_BITS-1:0]   regs_q,  regs_d;
  logic [31:0]           pc_q,    pc_d;
  logic [TNEW_W-1:0]     tnew_q,  tnew_d;
  logic [EXC_W-1:0]      exc_q,   exc_d;
  logic                  bd_q,    bd_d;

  // An excepting instruction only squashes when the slot is real
  assign squash_c = valid_in && (exc_in != '0);

  always_comb begin
    op_c = stg_op_sel(req, flush, stall, squash_c);
  end

  // Next-state for every field except the optional trace word
  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    regs_d  = regs_q;
    pc_d    = pc_q;
    tnew_d  = tnew_q;
    exc_d   = exc_q;
    bd_d    = bd_q;
    unique case (op_c)
      STG_REDIRECT: begin
        valid_d = 1'b0;
        ctrl_d  = '0;
        data_d  = '0;
        regs_d  = '0;
        pc_d    = EXC_VEC;
        tnew_d  = '0;
        exc_d   = '0;
        bd_d    = 1'b0;
      end
      STG_BUBBLE: begin
        // pc/bd still advance so CP0 sees the correct macroscopic PC
        valid_d = 1'b0;
        ctrl_d  = '0;
        data_d  = '0;
        regs_d  = '0;
        pc_d    = pc_in;
        tnew_d  = '0;
        exc_d   = '0;
        bd_d    = bd_in;
      end
      STG_HOLD: begin
      end
      STG_SQUASH: begin
        valid_d = 1'b1;
        ctrl_d  = '0;
        data_d  = '0;
        regs_d  = '0;
        pc_d    = pc_in;
        tnew_d  = '0;
        exc_d   = exc_in;
        bd_d    = bd_in;
      end
      default: begin
        valid_d = valid_in;
        ctrl_d  = ctrl_in;
        data_d  = data_in;
        regs_d  = regs_in;
        pc_d    = pc_in;
        tnew_d  = tnew_in;
        exc_d   = exc_in;
        bd_d    = bd_in;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
      regs_q  <= '0;
      pc_q    <= '0;
      tnew_q  <= '0;
      exc_q   <= '0;
      bd_q    <= 1'b0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
      regs_q  <= regs_d;
      pc_q    <= pc_d;
      tnew_q  <= tnew_d;
      exc_q   <= exc_d;
      bd_q    <= bd_d;
    end
  end

`ifdef PIPE_INSTR_TRACE_EN
  logic [31:0] instr_q, instr_d;

  always_comb begin
    instr_d = instr_q;
    unique case (op_c)
      STG_CAPTURE: instr_d = instr_in;
      STG_HOLD:    instr_d = instr_q;
      default:     instr_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) instr_q <= '0;
    else       instr_q <= instr_d;
  end

  assign instr_out = instr_q;
`else
  logic unused_instr;
  assign unused_instr = ^instr_in;
  assign instr_out    = '0;
`endif

  tnew_sat_dec #(.W(TNEW_W)) u_tnew_dec (
    .value (tnew_q),
    .dec_c (tnew_out)
  );

  assign valid_out = valid_q;
  assign ctrl_out  = ctrl_q;
  assign data_out  = data_q;
  assign regs_out  = regs_q;
  assign pc_out    = pc_q;
  assign exc_out   = exc_q;
  assign bd_out    = bd_q;

endmodule
